// File: rtl/fpu_div_issue.sv
// fpu_div_issue: issue/retire sequencer in front of the FP divide core.
//   clock/reset              clock, asynchronous active-high reset
//   inValid/inReady/inA/inB  operand stream into a DEPTH-entry FIFO
//   outValid/outReady/outResult/outCondCodes/outStatus  result stream
//   divIn1/divIn2/divStart/divReset  drive the core, one op at a time
//   divDone/divOut/divCondCodes/divStatus  core results (done is sticky)
//   busy        FSM active or operands queued
//   timeoutErr  sticky flag: an operation was aborted and returned qNaN
package fpu_div_pkg;
  typedef struct packed {logic sign; logic [4:0] exp; logic [9:0] frac;} fp16_t;
  typedef struct packed {logic z; logic c; logic n; logic v;} condCode_t;
  typedef struct packed {logic invalid; logic div_zero; logic overflow; logic underflow; logic inexact;} opStatusFlag_t;
endpackage

module fpu_div_issue
  import fpu_div_pkg::*;
#(
  parameter type FP_T = fp16_t,
  parameter int EXPW = 5,
  parameter int FRACW = 10,
  parameter int DEPTH = 2,
  parameter int TIMEOUT = 255
)(
  input  logic          clock,
  input  logic          reset,
  input  logic          inValid,
  output logic          inReady,
  input  FP_T           inA,
  input  FP_T           inB,
  output logic          outValid,
  input  logic          outReady,
  output FP_T           outResult,
  output condCode_t     outCondCodes,
  output opStatusFlag_t outStatus,
  output FP_T           divIn1,
  output FP_T           divIn2,
  output logic          divStart,
  output logic          divReset,
  input  logic          divDone,
  input  FP_T           divOut,
  input  condCode_t     divCondCodes,
  input  opStatusFlag_t divStatus,
  output logic          busy,
  output logic          timeoutErr
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(TIMEOUT + 1);
  localparam FP_T QNAN = FP_T'({1'b0, {EXPW{1'b1}}, 1'b1, {(FRACW - 1){1'b0}}});
  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_REARM} state_t;
  state_t state;
  FP_T mem_a [DEPTH];
  FP_T mem_b [DEPTH];
  logic [AW-1:0] wr, rd;
  logic [AW:0] count;
  logic [CW-1:0] tcnt;
  logic push, pop, slot_free, expired, cap;
  assign inReady   = count < (AW + 1)'(DEPTH);
  assign push      = inValid && inReady;
  assign pop       = state == S_IDLE && count != '0;
  assign slot_free = !outValid || outReady;
  assign expired   = tcnt == CW'(TIMEOUT);
  // A real result always wins over the timeout, even if it arrives late.
  assign cap       = state == S_WAIT && slot_free && (divDone || expired);
  assign divStart  = state == S_ISSUE;
  assign divReset  = reset || state == S_REARM;
  assign busy      = state != S_IDLE || count != '0;
  always_ff @(posedge clock)
    if (push) begin
      mem_a[wr] <= inA;
      mem_b[wr] <= inB;
    end
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      state        <= S_IDLE;
      wr           <= '0;
      rd           <= '0;
      count        <= '0;
      tcnt         <= '0;
      divIn1       <= '0;
      divIn2       <= '0;
      outValid     <= 1'b0;
      outResult    <= '0;
      outCondCodes <= '0;
      outStatus    <= '0;
      timeoutErr   <= 1'b0;
    end else begin
      wr    <= wr + AW'(push);
      rd    <= rd + AW'(pop);
      count <= count + (AW + 1)'(push) - (AW + 1)'(pop);
      case (state)
        S_IDLE:
          if (pop) begin
            divIn1 <= mem_a[rd];
            divIn2 <= mem_b[rd];
            state  <= S_ISSUE;
          end
        S_ISSUE: begin
          tcnt  <= '0;
          state <= S_WAIT;
        end
        S_WAIT:
          // Counter freezes while the core holds a result for a busy slot.
          if (cap) state <= S_REARM;
          else if (!divDone && !expired) tcnt <= tcnt + 1'b1;
        default: state <= S_IDLE;
      endcase
      outValid <= cap || (outValid && !outReady);
      if (cap) begin
        outResult    <= divDone ? divOut : QNAN;
        outCondCodes <= divDone ? divCondCodes : '0;
        outStatus    <= divDone ? divStatus : '0;
      end
      if (cap && !divDone) timeoutErr <= 1'b1;
    end
endmodule

// File: tb/tb_fpu_div_issue.sv
// tb_fpu_div_issue: directed self-checking bench with a small divide-core model.
module tb_fpu_div_issue;
  import fpu_div_pkg::*;
  localparam int LAT = 5;
  logic clock = 0, reset = 1;
  logic inValid = 0, outReady = 1, divDone = 0;
  logic inReady, outValid, divStart, divReset, busy, timeoutErr;
  logic [15:0] inA = 0, inB = 0, divOut = 0, outResult, divIn1, divIn2;
  logic [3:0] divCondCodes = 0, outCondCodes;
  logic [4:0] divStatus = 0, outStatus;
  int checks = 0, failures = 0, starts = 0, rearms = 0, ccnt = 0;
  int k, base, s0, r0;
  logic core_run = 0, hang = 0;
  logic [24:0] got[$];
  logic [15:0] vals [8] = '{16'h3C00, 16'hC200, 16'h0000, 16'h4500, 16'h4880, 16'hBC00, 16'h7BFF, 16'h0001};

  always #5 clock = ~clock;

  fpu_div_issue #(.TIMEOUT(8)) dut (
    .clock(clock), .reset(reset), .inValid(inValid), .inReady(inReady), .inA(inA), .inB(inB),
    .outValid(outValid), .outReady(outReady), .outResult(outResult), .outCondCodes(outCondCodes),
    .outStatus(outStatus), .divIn1(divIn1), .divIn2(divIn2), .divStart(divStart), .divReset(divReset),
    .divDone(divDone), .divOut(divOut), .divCondCodes(divCondCodes), .divStatus(divStatus),
    .busy(busy), .timeoutErr(timeoutErr));

  // Exact fp16 quotients for the operand pairs used here.
  function automatic logic [15:0] quot(input logic [15:0] a, input logic [15:0] b);
    if (b == 16'h3C00) return a;
    if (b == 16'h4000 && a == 16'h4600) return 16'h4200;
    if (b == 16'h4000 && a == 16'h3C00) return 16'h3800;
    if (b == 16'h4000 && a == 16'h4200) return 16'h3E00;
    return 16'hFFFF;
  endfunction

  function automatic logic [3:0] cc_of(input logic [15:0] q);
    return {q[14:0] == 15'd0, 1'b0, q[15], 1'b0};
  endfunction

  // Core model: done becomes visible LAT edges after the edge that samples divStart,
  // and stays high until divReset.
  always @(posedge clock) begin
    if (divReset) begin
      divDone  <= 1'b0;
      core_run <= 1'b0;
    end else if (divStart) begin
      core_run <= 1'b1;
      ccnt     <= 1;
    end else if (core_run && !hang) begin
      ccnt <= ccnt + 1;
      if (ccnt == LAT) begin
        divDone      <= 1'b1;
        divOut       <= quot(divIn1, divIn2);
        divCondCodes <= cc_of(quot(divIn1, divIn2));
        divStatus    <= 5'b00001;
      end
    end
  end

  always @(posedge clock)
    if (!reset) begin
      if (divStart) starts <= starts + 1;
      if (divReset) rearms <= rearms + 1;
      if (outValid && outReady) got.push_back({outResult, outCondCodes, outStatus});
    end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [15:0] a, input logic [15:0] b);
    int t = 0;
    inValid = 1; inA = a; inB = b;
    while (!inReady && t < 200) begin @(negedge clock); t++; end
    if (t >= 200) check("push_bound", 0, 1);
    @(negedge clock);
    inValid = 0;
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    while (!outValid && n < 200) begin @(negedge clock); n++; end
    if (n >= 200) check("valid_bound", 0, 1);
  endtask

  task automatic wait_got(input int n);
    int t = 0;
    while (got.size() < n && t < 300) begin @(negedge clock); t++; end
    if (t >= 300) check("result_bound", 0, 1);
  endtask

  initial begin
    @(negedge clock);
    check("rst_inReady", inReady, 1);
    check("rst_outValid", outValid, 0);
    check("rst_outResult", outResult, 0);
    check("rst_outCond", outCondCodes, 0);
    check("rst_divStart", divStart, 0);
    check("rst_divReset", divReset, 1);
    check("rst_busy", busy, 0);
    check("rst_timeoutErr", timeoutErr, 0);
    check("rst_divIn1", divIn1, 0);
    reset = 0;
    @(negedge clock);

    // Single op: pop at E+1, start E+1..E+2, done seen E+8, REARM during the cycle after capture.
    s0 = starts; r0 = rearms;
    push(16'h4600, 16'h4000);
    check("single_idle_after_accept", divStart, 0);
    @(negedge clock);
    check("single_start", divStart, 1);
    check("single_divIn1", divIn1, 16'h4600);
    check("single_divIn2", divIn2, 16'h4000);
    @(negedge clock);
    check("single_start_low", divStart, 0);
    check("single_busy", busy, 1);
    k = 2;
    while (!outValid && k < 100) begin @(negedge clock); k++; end
    check("single_latency", k, 8);
    check("single_result", outResult, 16'h4200);
    check("single_cond", outCondCodes, 4'b0000);
    check("single_status", outStatus, 5'b00001);
    check("single_rearm", divReset, 1);
    @(negedge clock);
    check("single_consumed", outValid, 0);
    check("single_idle", busy, 0);
    check("single_start_count", starts - s0, 1);
    check("single_rearm_count", rearms - r0, 1);

    // Back-pressure: three pairs with the consumer stalled.
    outReady = 0; s0 = starts; base = got.size();
    push(16'h3C00, 16'h4000);
    push(16'h4000, 16'h3C00);
    push(16'h4200, 16'h4000);
    check("bp_full", inReady, 0);
    repeat (30) @(negedge clock);
    check("bp_valid", outValid, 1);
    check("bp_head", outResult, 16'h3800);
    check("bp_issued", starts - s0, 2);
    check("bp_no_timeout", timeoutErr, 0);
    check("bp_ready_again", inReady, 1);
    outReady = 1;
    wait_got(base + 3);
    repeat (3) @(negedge clock);
    check("bp_count", got.size() - base, 3);
    check("bp_r0", got[base][24:9], 16'h3800);
    check("bp_r1", got[base+1][24:9], 16'h4000);
    check("bp_r2", got[base+2][24:9], 16'h3E00);

    // Eight ops streamed through the 2-entry FIFO (pointer wrap), x/1.0 = x.
    base = got.size(); s0 = starts;
    for (int i = 0; i < 8; i++) push(vals[i], 16'h3C00);
    wait_got(base + 8);
    repeat (3) @(negedge clock);
    check("wrap_count", got.size() - base, 8);
    check("wrap_starts", starts - s0, 8);
    for (int i = 0; i < 8; i++) check($sformatf("wrap_r%0d", i), got[base+i][24:9], vals[i]);
    check("wrap_neg_cc", got[base+1][8:5], 4'b0010);
    check("wrap_zero_cc", got[base+2][8:5], 4'b1000);

    // Timeout (TIMEOUT=8): core never finishes, qNaN returned at E+11.
    hang = 1;
    push(16'h4600, 16'h4000);
    wait_valid(k);
    check("to_latency", k, 11);
    check("to_result", outResult, 16'h7E00);
    check("to_cond", outCondCodes, 0);
    check("to_status", outStatus, 0);
    check("to_err", timeoutErr, 1);
    check("to_rearm", divReset, 1);
    hang = 0;
    @(negedge clock);
    push(16'h3C00, 16'h4000);
    wait_valid(k);
    check("to_next_result", outResult, 16'h3800);
    check("to_next_status", outStatus, 5'b00001);
    check("to_err_sticky", timeoutErr, 1);
    @(negedge clock);

    // Consume and capture in the same cycle.
    outReady = 0; base = got.size();
    push(16'h4000, 16'h3C00);
    push(16'h4200, 16'h4000);
    repeat (30) @(negedge clock);
    check("stall_old", outResult, 16'h4000);
    outReady = 1;
    check("stall_valid_pre", outValid, 1);
    @(negedge clock);
    check("stall_valid_kept", outValid, 1);
    check("stall_new", outResult, 16'h3E00);
    @(negedge clock);
    check("stall_drained", outValid, 0);
    check("stall_count", got.size() - base, 2);
    check("stall_r0", got[base][24:9], 16'h4000);
    check("stall_r1", got[base+1][24:9], 16'h3E00);

    // Reset during WAIT with one entry queued.
    hang = 1;
    push(16'h4600, 16'h4000);
    push(16'h3C00, 16'h4000);
    repeat (3) @(negedge clock);
    check("mid_busy", busy, 1);
    s0 = starts;
    reset = 1;
    #1;
    check("mid_outValid", outValid, 0);
    check("mid_inReady", inReady, 1);
    check("mid_busy_clr", busy, 0);
    check("mid_divReset", divReset, 1);
    @(negedge clock);
    hang = 0; reset = 0;
    repeat (12) @(negedge clock);
    check("mid_no_start", starts - s0, 0);
    check("mid_idle", busy, 0);
    check("mid_no_valid", outValid, 0);
    push(16'h4200, 16'h4000);
    wait_valid(k);
    check("mid_resume", outResult, 16'h3E00);
    check("mid_err_cleared", timeoutErr, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
